layer_channel_packer: RTL and testbench
=======================================

Name: layer_channel_packer

Overview:
- Write side of the packed channel bus consumed by every layer featuremap block.
- Collects one FP32 activation word per cycle, in channel-major order (ch0..ch(N-1) for one pixel). Emits the pixel as one DATA_IN_WIDTH-bit vector with a valid pulse, in the lane layout the featuremaps slice.
- Sits between the previous layer's serial output stream and the next layer's featuremap bank.
- Tracks pixel position within the frame and flags the last pixel.

Parameters:
- DATA_WIDTH, 32, width of one FP32 channel word.
- NUM_CHANNELS, 16, channels per pixel.
- DATA_IN_WIDTH, 512, packed output width; must equal DATA_WIDTH*NUM_CHANNELS.
- IMG_SIZE, 208, feature map side length; frame = IMG_SIZE*IMG_SIZE pixels.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  one channel word.
- valid_in  input  1  data_in valid.
- ready_in  output  1  packer can accept data_in this cycle.
- data_out  output  DATA_IN_WIDTH  packed pixel; channel k in bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- valid_out  output  1  data_out holds a complete pixel.
- out_ready  input  1  downstream accepts data_out; tied 1 when feeding featuremaps.
- frame_last  output  1  data_out is the last pixel of the frame; qualified by valid_out.

Behaviour:
- Accept: a word is accepted when valid_in && ready_in. No state changes on cycles where valid_in=0.
- ch_cnt counts 0..NUM_CHANNELS-1. An accepted word is written to lane ch_cnt of the assembly register, then ch_cnt increments. It wraps to 0 after lane NUM_CHANNELS-1.
- Drain: the output register drains when valid_out && out_ready.
- Completion: accepting lane NUM_CHANNELS-1 completes a pixel. On the next edge:
  - the full assembly contents, including the current word, load into the output register;
  - valid_out=1;
  - frame_last is set if pix_cnt==IMG_SIZE*IMG_SIZE-1;
  - pix_cnt increments, wrapping to 0 after the last pixel.
- Latency: last word accepted at cycle t, so valid_out=1 with that data at t+1.
- Back-to-back pixels with out_ready=1: one vector every NUM_CHANNELS cycles, with no bubbles on the input.
- ready_in = !Rst && !(ch_cnt==NUM_CHANNELS-1 && valid_out && !out_ready). This is combinational from out_ready.
  - Lanes 0..N-2 are always accepted while the output is stalled.
  - Only the completing word waits.
- Simultaneous drain and completion in the same cycle: the new vector loads and valid_out stays 1; no drop, no duplicate.
- Drain without completion: valid_out->0 and frame_last->0 on the next edge.
- Held output: data_out and frame_last are stable while valid_out && !out_ready.
- Reset:
  - valid_out=0, data_out=0, frame_last=0, ch_cnt=0, pix_cnt=0;
  - assembly register cleared;
  - ready_in=0 during any cycle Rst=1.
- Mid-operation reset: any partial pixel and any undrained output vector are discarded. The first word after reset is lane 0 of pixel 0.
- No arithmetic on data; words pass bit-exact. pix_cnt width = clog2(IMG_SIZE*IMG_SIZE), 16 bits at the default.

Decomposition:
- Shared package layer_pkg: DATA_WIDTH, NUM_CHANNELS, DATA_IN_WIDTH, IMG_SIZE, and derived FRAME_PIXELS and PIX_CNT_W constants.
- One natural sub-module, mod_counter: parameterised modulus, enable, sync reset, terminal-count output. It is used twice, for ch_cnt (modulus NUM_CHANNELS) and pix_cnt (modulus FRAME_PIXELS).
- Lane write decode and the output register stay in the top module.

Test Plan:
- Reset then 16 words 32'h3F800000+k (k=0..15) back-to-back, out_ready=1 -> one cycle after the 16th accept:
  - valid_out=1 for exactly one cycle;
  - data_out[31:0]=3F800000, data_out[511:480]=3F80000F;
  - ready_in stays 1 throughout.
- 3 consecutive pixels, out_ready=1, valid_in continuous -> valid_out pulses every 16 cycles, each vector's lanes correct, no input stall.
- out_ready=0 after pixel 0 completes, then feed 16 more words:
  - words 0..14 accepted;
  - ready_in=0 on word 15 until out_ready=1;
  - pixel 0 data held stable;
  - pixel 1 appears the cycle after its accept.
- valid_in gaps (random 0–3 idle cycles between words) -> identical output vectors to the gap-free run; ch_cnt does not advance on idle cycles.
- IMG_SIZE=4 override, feed 17 pixels:
  - frame_last=1 only with pixel 15;
  - pixel 16 has frame_last=0, confirming pix_cnt wrapped to 0.
- Rst pulsed after word 7 of a pixel -> valid_out=0, data_out=0, ready_in=0 during reset. The next 16 words form a complete pixel 0, with no residue from the discarded lanes.

Source files
------------

// File: rtl/layer_pkg.sv
// ============================================================================
// Module      : layer_pkg
// Description : Shared sizing constants for the layer channel bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_CHANNELS  = 16;
    localparam int DATA_IN_WIDTH = DATA_WIDTH * NUM_CHANNELS;
    localparam int IMG_SIZE      = 208;
    localparam int FRAME_PIXELS  = IMG_SIZE * IMG_SIZE;
    localparam int PIX_CNT_W     = $clog2(FRAME_PIXELS);

    // A modulus-1 counter still needs one register bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer_channel_packer_mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Enabled modulo-N up counter with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
    import layer_pkg::*;
#(
    parameter int MODULUS = 16,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/layer_channel_packer.sv
// ============================================================================
// Module      : layer_channel_packer
// Description : Packs a channel-serial FP32 stream into one wide pixel vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_channel_packer #(
    parameter int DATA_WIDTH    = layer_pkg::DATA_WIDTH,
    parameter int NUM_CHANNELS  = layer_pkg::NUM_CHANNELS,
    parameter int DATA_IN_WIDTH = DATA_WIDTH * NUM_CHANNELS,
    parameter int IMG_SIZE      = layer_pkg::IMG_SIZE
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [DATA_IN_WIDTH-1:0] data_out,
    output logic                     valid_out,
    input  logic                     out_ready,
    output logic                     frame_last
);

    import layer_pkg::*;

    localparam int c_FRAME_PIXELS = IMG_SIZE * IMG_SIZE;
    localparam int c_PIX_CNT_W    = cnt_width(c_FRAME_PIXELS);
    localparam int c_CH_CNT_W     = cnt_width(NUM_CHANNELS);

    localparam logic [c_PIX_CNT_W-1:0] c_PIX_LAST = c_PIX_CNT_W'(c_FRAME_PIXELS - 1);

    logic                                   w_accept;
    logic                                   w_complete;
    logic                                   w_drain;
    logic                                   w_ch_tc;
    logic                                   w_unused_pix_tc;
    logic [c_CH_CNT_W-1:0]                  w_ch_cnt;
    logic [c_PIX_CNT_W-1:0]                 w_pix_cnt;
    logic [NUM_CHANNELS-1:0]                w_lane_we;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] w_full_pix;

    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_asm;
    logic [DATA_IN_WIDTH-1:0]               r_data_out;
    logic                                   r_valid_out;
    logic                                   r_frame_last;

    // Only the completing word can be blocked; earlier lanes never touch the output.
    assign ready_in   = !Rst && !(w_ch_tc && r_valid_out && !out_ready);
    assign w_accept   = valid_in && ready_in;
    assign w_complete = w_accept && w_ch_tc;
    assign w_drain    = r_valid_out && out_ready;

    mod_counter #(
        .MODULUS (NUM_CHANNELS),
        .WIDTH   (c_CH_CNT_W)
    ) u_ch_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_en    (w_accept),
        .o_count (w_ch_cnt),
        .o_tc    (w_ch_tc)
    );

    mod_counter #(
        .MODULUS (c_FRAME_PIXELS),
        .WIDTH   (c_PIX_CNT_W)
    ) u_pix_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_en    (w_complete),
        .o_count (w_pix_cnt),
        .o_tc    (w_unused_pix_tc)
    );

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
            assign w_lane_we[g] = w_accept && (w_ch_cnt == c_CH_CNT_W'(g));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_asm <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (w_lane_we[k]) begin
                    r_asm[k] <= data_in;
                end
            end
        end
    end

    // The completing word bypasses the assembly register so the pixel lands one edge later.
    always_comb begin
        w_full_pix                 = r_asm;
        w_full_pix[NUM_CHANNELS-1] = data_in;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_last <= 1'b0;
        end else if (w_complete) begin
            r_data_out   <= w_full_pix;
            r_valid_out  <= 1'b1;
            r_frame_last <= (w_pix_cnt == c_PIX_LAST);
        end else if (w_drain) begin
            r_valid_out  <= 1'b0;
            r_frame_last <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign frame_last = r_frame_last;

endmodule

`default_nettype wire

// File: tb/tb_layer_channel_packer.sv
// ============================================================================
// Module      : tb_layer_channel_packer
// Description : Directed self-checking bench for layer_channel_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_channel_packer;

    localparam int DW  = 32;
    localparam int NC  = 16;
    localparam int DIW = 512;
    localparam int IMG = 4;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic [DW-1:0]  data_in = '0;
    logic           valid_in = 1'b0;
    logic           out_ready = 1'b1;
    wire            ready_in;
    wire            valid_out;
    wire            frame_last;
    wire  [DIW-1:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DIW-1:0] exp_pix;

    always #5 Clk = ~Clk;

    layer_channel_packer #(
        .DATA_WIDTH    (DW),
        .NUM_CHANNELS  (NC),
        .DATA_IN_WIDTH (DIW),
        .IMG_SIZE      (IMG)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .out_ready  (out_ready),
        .frame_last (frame_last)
    );

    task automatic chk(input string tag, input logic [DIW-1:0] obs, input logic [DIW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [DIW-1:0] mkpix(input logic [DW-1:0] base);
        logic [DIW-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) begin
            v[k*DW +: DW] = base + DW'(k);
        end
        return v;
    endfunction

    // Sixteen back-to-back words; the pixel must appear exactly after the last one.
    task automatic feed_pixel(input logic [DW-1:0] base, input logic exp_last, input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < NC; k++) begin
            data_in  = base + DW'(k);
            valid_in = 1'b1;
            #1;
            chk({tag, "/ready"}, DIW'(ready_in), DIW'(1'b1));
            tick();
            chk({tag, "/valid"}, DIW'(valid_out), DIW'(k == NC - 1));
            if (k == NC - 1) begin
                chk({tag, "/data"}, data_out, mkpix(base));
                chk({tag, "/last"}, DIW'(frame_last), DIW'(exp_last));
            end else begin
                chk({tag, "/last_lo"}, DIW'(frame_last), DIW'(1'b0));
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        // Reset with a live input: nothing may be accepted.
        Rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'hBAD0BAD0;
        repeat (3) tick();
        chk("rst/valid", DIW'(valid_out), DIW'(1'b0));
        chk("rst/data", data_out, '0);
        chk("rst/last", DIW'(frame_last), DIW'(1'b0));
        chk("rst/ready", DIW'(ready_in), DIW'(1'b0));
        Rst      = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rst/ready_after", DIW'(ready_in), DIW'(1'b1));

        // Pixel 0: basic packing and lane order.
        feed_pixel(32'h3F800000, 1'b0, "p0");
        chk("p0/lane0", DIW'(data_out[31:0]), DIW'(32'h3F800000));
        chk("p0/lane15", DIW'(data_out[511:480]), DIW'(32'h3F80000F));
        tick();
        chk("p0/one_cycle", DIW'(valid_out), DIW'(1'b0));

        // Pixels 1..3 continuous.
        for (int p = 1; p <= 3; p++) begin
            feed_pixel(32'h40000000 + DW'(p * 16), 1'b0, "burst");
        end
        tick();
        chk("burst/drain", DIW'(valid_out), DIW'(1'b0));

        // Pixel 4 then a stalled pixel 5.
        feed_pixel(32'h41000000, 1'b0, "p4");
        out_ready = 1'b0;
        exp_pix   = mkpix(32'h41000000);
        for (int k = 0; k < NC - 1; k++) begin
            data_in  = 32'h42000000 + DW'(k);
            valid_in = 1'b1;
            #1;
            chk("stall/ready_lo_lanes", DIW'(ready_in), DIW'(1'b1));
            tick();
            chk("stall/held_valid", DIW'(valid_out), DIW'(1'b1));
            chk("stall/held_data", data_out, exp_pix);
        end
        data_in = 32'h4200000F;
        #1;
        chk("stall/ready_blocked", DIW'(ready_in), DIW'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall/wait_valid", DIW'(valid_out), DIW'(1'b1));
            chk("stall/wait_data", data_out, exp_pix);
            chk("stall/wait_ready", DIW'(ready_in), DIW'(1'b0));
        end
        out_ready = 1'b1;
        #1;
        chk("stall/ready_release", DIW'(ready_in), DIW'(1'b1));
        tick();
        chk("stall/p5_valid", DIW'(valid_out), DIW'(1'b1));
        chk("stall/p5_data", data_out, mkpix(32'h42000000));
        chk("stall/p5_last", DIW'(frame_last), DIW'(1'b0));
        valid_in = 1'b0;
        tick();
        chk("stall/p5_drain", DIW'(valid_out), DIW'(1'b0));

        // Pixel 6 with idle gaps between words.
        for (int k = 0; k < NC; k++) begin
            valid_in = 1'b0;
            data_in  = 32'hDEADBEEF;
            for (int g = 0; g < (k * 3 + 1) % 4; g++) begin
                tick();
                chk("gap/idle_valid", DIW'(valid_out), DIW'(1'b0));
            end
            data_in  = 32'h43000000 + DW'(k);
            valid_in = 1'b1;
            tick();
            chk("gap/valid", DIW'(valid_out), DIW'(k == NC - 1));
        end
        valid_in = 1'b0;
        chk("gap/data", data_out, mkpix(32'h43000000));
        chk("gap/last", DIW'(frame_last), DIW'(1'b0));

        // Pixels 7..16: frame_last only on pixel 15, then the counter wraps.
        for (int p = 7; p <= 16; p++) begin
            feed_pixel(32'h50000000 + DW'(p << 8), p == 15, "frame");
        end

        // Reset with an undrained vector and a half-built pixel.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            data_in  = 32'h60000000 + DW'(k);
            valid_in = 1'b1;
            tick();
        end
        Rst      = 1'b1;
        data_in  = 32'hBAD1BAD1;
        #1;
        chk("mrst/ready", DIW'(ready_in), DIW'(1'b0));
        tick();
        chk("mrst/valid", DIW'(valid_out), DIW'(1'b0));
        chk("mrst/data", data_out, '0);
        chk("mrst/last", DIW'(frame_last), DIW'(1'b0));
        chk("mrst/ready_hold", DIW'(ready_in), DIW'(1'b0));
        Rst      = 1'b0;
        valid_in = 1'b0;
        for (int p = 0; p < IMG * IMG; p++) begin
            feed_pixel(32'h70000000 + DW'(p << 8), p == IMG * IMG - 1, "post_rst");
        end
        tick();
        chk("post_rst/drain", DIW'(valid_out), DIW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
